branch_redirect_ctrl: RTL

BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

---
 rtl/branch_redirect_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - branch/jump redirect and pipeline flush sequencer
//
// Resolves taken branches and jumps in EX, steers fetch to the target and
// squashes the IF/ID and ID/EX registers for FLUSH_CYCLES cycles.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   ex_valid        EX holds a valid instruction
//   ex_is_branch    EX instruction is a conditional branch
//   ex_is_jump      EX instruction is JAL/JALR (always taken)
//   branch_sel      comparator result, 1 = branch condition true
//   ex_target       computed target address
//   stall_in        pipeline hold, EX not consumed this cycle
//   redirect_valid  fetch must load redirect_pc
//   redirect_pc     registered target, word aligned
//   flush_if        squash IF/ID
//   flush_id        squash ID/EX
//   misalign_err    one-cycle pulse on a taken, misaligned target
//   busy            sequencer not idle
//   branch_count    conditional branches resolved (saturating)
//   taken_count     redirects issued (saturating)
module branch_redirect_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_is_jump,
  input  logic             branch_sel,
  input  logic [31:0]      ex_target,
  input  logic             stall_in,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush_if,
  output logic             flush_id,
  output logic             misalign_err,
  output logic             busy,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REDIR = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // REDIR already accounts for the first flush cycle, so FLUSH runs the rest.
  localparam logic [3:0] FLUSH_LOAD = (FLUSH_CYCLES >= 2) ? 4'(FLUSH_CYCLES - 2) : 4'd0;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state;
  logic [3:0] flush_cnt;

  logic take;
  logic branch_seen;
  logic target_aligned;

  // A jump wins over branch_sel when both type flags are set.
  assign take           = ex_valid & ~stall_in & ((ex_is_branch & branch_sel) | ex_is_jump);
  assign branch_seen    = ex_valid & ex_is_branch & ~stall_in;
  assign target_aligned = (ex_target[1:0] == 2'b00);

  // Outputs below are pure decodes of the state register.
  assign redirect_valid = (state == REDIR);
  assign flush_if       = (state != IDLE);
  assign flush_id       = (state != IDLE);
  assign busy           = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      redirect_pc  <= 32'd0;
      misalign_err <= 1'b0;
      flush_cnt    <= 4'd0;
      branch_count <= '0;
      taken_count  <= '0;
    end else begin
      misalign_err <= 1'b0;
      case (state)
        IDLE: begin
          if (branch_seen && (branch_count != '1)) begin
            branch_count <= branch_count + CNT_ONE;
          end
          if (take) begin
            if (target_aligned) begin
              state       <= REDIR;
              redirect_pc <= {ex_target[31:2], 2'b00};
              if (taken_count != '1) begin
                taken_count <= taken_count + CNT_ONE;
              end
            end else begin
              misalign_err <= 1'b1;
            end
          end
        end
        REDIR: begin
          // Fetch may not accept the redirect while stalled; hold it.
          if (!stall_in) begin
            if (FLUSH_CYCLES == 1) begin
              state <= IDLE;
            end else begin
              state     <= FLUSH;
              flush_cnt <= FLUSH_LOAD;
            end
          end
        end
        FLUSH: begin
          // Flush length is fixed in cycles; stalls do not extend it.
          if (flush_cnt == 4'd0) begin
            state <= IDLE;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
